io_uart: RTL and testbench
==========================

IO_UART -- requirements
Module: io_uart

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, >=2) SHALL be supported.
REQ-002 Parameter DIV_RESET, default 434, baud divisor reset value (clk cycles per bit) SHALL be supported.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 ce  input  1  bus chip enable from CPU IO port; access valid only when high.
REQ-006 we  input  1  write strobe; write when ce&&we at clk edge.
REQ-007 addr  input  32  byte address; only addr[3:2] SHALL be decoded.
REQ-008 dataIn  input  32  write data.
REQ-009 dataOut  output  32  read data, combinational from ce/addr/state.
REQ-010 txd  output  1  serial line, registered, idle high.

Function
REQ-011 Register map (addr[3:2]): 0 TXDATA (W), 1 STATUS (R/W1C), 2 DIVISOR (R/W, bits[15:0]), 3 reserved (reads 0, writes ignored).
REQ-012 dataOut SHALL be 0 when ce=0, and for TXDATA reads.
REQ-013 STATUS read: bit0 busy (state!=IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count (saturated at 15), others 0.
REQ-014 Write TXDATA: dataIn[7:0] pushed; accepted if FIFO not full or a pop occurs same cycle; otherwise dropped and overflow set.
REQ-015 Write STATUS with dataIn[3]=1 SHALL clear overflow; an overflow event in the same cycle wins (stays 1).
REQ-016 Write DIVISOR: value 0 SHALL be stored but treated as 1; new value takes effect at the next bit-period reload, never truncating the current bit.
REQ-017 FSM states IDLE, START, DATA, STOP.
REQ-018 IDLE: if FIFO non-empty at an edge, pop head into shift register, enter START, txd<=0, reload bit timer.
REQ-019 START: after divisor cycles go DATA, txd<=bit0.
REQ-020 DATA: LSB first, 8 bits, each divisor cycles; after bit7 go STOP, txd<=1.
REQ-021 STOP: after divisor cycles, if FIFO non-empty pop and enter START directly (no idle cycle); else IDLE.
REQ-022 Frame length SHALL be exactly 10*divisor cycles; back-to-back frames SHALL have no gap.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count tracks simultaneous push+pop (count unchanged).
REQ-024 Push into empty FIFO while IDLE: earliest pop is the following edge (1-cycle write-to-start latency).

Reset
REQ-025 On rst at an edge: state IDLE, txd=1, FIFO emptied (pointers/count 0), overflow 0, divisor DIV_RESET, bit timer and bit counter 0.
REQ-026 Reset mid-frame SHALL abort the frame immediately; txd high next cycle; bus writes in a reset cycle ignored.

Structure
REQ-027 Register offsets, STATUS bit positions and FSM state encoding SHALL reside in shared package io_pkg.
REQ-028 FIFO SHALL be sub-module io_fifo (push/pop/full/empty/count); FSM, timer and bus decode in io_uart.

Verification
REQ-029 DIVISOR=4, write TXDATA 0x55: txd low 1 cycle after write, then 0,1,0,1,0,1,0,1,0,1 each 4 cycles, busy=0 after 40 cycles.
REQ-030 DIVISOR=2, write 9 bytes back-to-back while IDLE: first pops immediately, 8 queue, none dropped, overflow=0; 10th write -> dropped, STATUS bit3=1; W1C clears it.
REQ-031 Three queued bytes 0x01,0x80,0xFF at DIVISOR=3: 90 contiguous txd cycles, stop bit then next start bit with no idle cycle.
REQ-032 FIFO full and STOP completing in same cycle as TXDATA write: write accepted, count stays 8, overflow=0.
REQ-033 Assert rst during DATA bit 3: next cycle txd=1, STATUS reads 0x04, DIVISOR reads DIV_RESET.
REQ-034 DIVISOR write 0 then write 0xA5: each bit lasts 1 cycle; DIVISOR readback 0; reserved address reads 0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the io_uart transmitter: register offsets,
// STATUS bit positions and transmitter FSM encoding.
package io_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_CNT_LSB   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  // STATUS has a 4-bit count field; deeper FIFOs report 15 when fuller.
  function automatic logic [3:0] sat_count(input logic [15:0] cnt);
    return (cnt > 16'd15) ? 4'hF : cnt[3:0];
  endfunction

endpackage

// File: rtl/io_uart_if.sv
// CPU IO-port bus as seen by the UART: chip enable, write strobe,
// byte address, write data and combinational read data.
interface io_uart_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] dataIn;
  logic [31:0] dataOut;

  modport master (output ce, we, addr, dataIn, input dataOut);
  modport slave  (input ce, we, addr, dataIn, output dataOut);
endinterface

// File: rtl/io_fifo.sv
// Byte FIFO for the transmit path. A push into a full FIFO is accepted
// when a pop happens in the same cycle.
module io_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  // DEPTH is a power of two, so count can only reach DEPTH with its MSB set.
  assign full    = count_q[AW];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; empty pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped UART transmitter: bus decode, baud timer and 8N1 framing
// FSM fed from an io_fifo transmit queue.
module io_uart
  import io_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic      clk,
  input  logic      rst,
  io_uart_if.slave  bus,
  output logic      txd
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_e state_q, state_d;
  logic        txd_q, txd_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic        wr_tx, wr_status, wr_div, ovf_event, bit_done;
  logic [15:0] reload;
  logic [31:0] status_word;
  logic        unused_bus_bits;

  assign wr_tx     = bus.ce && bus.we && (bus.addr[3:2] == REG_TXDATA);
  assign wr_status = bus.ce && bus.we && (bus.addr[3:2] == REG_STATUS);
  assign wr_div    = bus.ce && bus.we && (bus.addr[3:2] == REG_DIVISOR);
  assign unused_bus_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.dataIn[31:16]};

  // A stored divisor of 0 behaves as 1; the timer counts reload..0 per bit.
  assign reload    = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign bit_done  = (timer_q == 16'd0);
  assign ovf_event = wr_tx && fifo_full && !fifo_pop;
  assign txd       = txd_q;

  io_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .wdata (bus.dataIn[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    txd_d     = txd_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = timer_q - 16'd1;
    fifo_pop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_START;
          txd_d    = 1'b0;
          shift_d  = fifo_rdata;
          timer_d  = reload;
        end
      end
      S_START: if (bit_done) begin
        state_d   = S_DATA;
        txd_d     = shift_q[0];
        shift_d   = {1'b0, shift_q[7:1]};
        bit_cnt_d = '0;
        timer_d   = reload;
      end
      S_DATA: if (bit_done) begin
        timer_d = reload;
        if (bit_cnt_q == 3'd7) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          txd_d     = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
        end
      end
      S_STOP: if (bit_done) begin
        // Chain straight into the next start bit so queued frames have no gap.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_START;
          txd_d    = 1'b0;
          shift_d  = fifo_rdata;
          timer_d  = reload;
        end else begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_div) div_d = bus.dataIn[15:0];
    if (wr_status && bus.dataIn[ST_OVF_BIT]) ovf_d = 1'b0;
    if (ovf_event) ovf_d = 1'b1;
  end

  always_comb begin
    status_word                       = '0;
    status_word[ST_BUSY_BIT]          = (state_q != S_IDLE);
    status_word[ST_FULL_BIT]          = fifo_full;
    status_word[ST_EMPTY_BIT]         = fifo_empty;
    status_word[ST_OVF_BIT]           = ovf_q;
    status_word[ST_CNT_LSB +: 4]      = sat_count(16'(fifo_count));
    bus.dataOut = '0;
    if (bus.ce) begin
      case (bus.addr[3:2])
        REG_STATUS:  bus.dataOut = status_word;
        REG_DIVISOR: bus.dataOut = {16'h0000, div_q};
        default:     bus.dataOut = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      txd_q     <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      div_q     <= DIV_RESET;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      txd_q     <= txd_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Self-checking bench for io_uart: a queue-based line model compared every
// cycle, plus directed frames with literal bit patterns.
module tb_io_uart;
  import io_pkg::*;

  localparam int          DEPTH = 8;
  localparam logic [15:0] DIVR  = 16'd434;

  logic clk = 1'b0;
  logic rst;
  logic txd;
  int   checks = 0;
  int   errors = 0;

  io_uart_if bus_if();

  io_uart #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIVR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if),
    .txd (txd)
  );

  always #5 clk = ~clk;

  // Model: pending bytes, plus the per-cycle line levels still to be sent.
  logic [7:0]  m_fifo[$];
  logic        m_line[$];
  logic        m_ovf;
  logic [15:0] m_div;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    int cnt;
    r   = '0;
    cnt = m_fifo.size();
    case (a)
      2'd1: begin
        r[0]   = (m_line.size() != 0);
        r[1]   = (cnt == DEPTH);
        r[2]   = (cnt == 0);
        r[3]   = m_ovf;
        r[7:4] = (cnt > 15) ? 4'd15 : 4'(cnt);
      end
      2'd2:    r[15:0] = m_div;
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin : model_p
    logic [7:0] b;
    logic [1:0] a;
    logic       wr;
    int         d;
    if (rst) begin
      m_fifo.delete();
      m_line.delete();
      m_ovf = 1'b0;
      m_div = DIVR;
    end else begin
      if (m_line.size() > 0) void'(m_line.pop_front());
      wr = bus_if.ce && bus_if.we;
      a  = bus_if.addr[3:2];
      if (m_line.size() == 0 && m_fifo.size() > 0) begin
        b = m_fifo.pop_front();
        d = (m_div == 16'd0) ? 1 : int'(m_div);
        for (int i = 0; i < 10; i++)
          for (int j = 0; j < d; j++)
            m_line.push_back((i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1]);
      end
      if (wr && a == 2'd0) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(bus_if.dataIn[7:0]);
        else m_ovf = 1'b1;
      end
      if (wr && a == 2'd1 && bus_if.dataIn[3]) m_ovf = 1'b0;
      if (wr && a == 2'd2) m_div = bus_if.dataIn[15:0];
    end
    #1;
    check("model_txd", 32'(txd), 32'((m_line.size() > 0) ? m_line[0] : 1'b1));
    if (bus_if.ce) check("model_dataout", bus_if.dataOut, m_read(bus_if.addr[3:2]));
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.ce     = 1'b1;
    bus_if.we     = 1'b1;
    bus_if.addr   = 32'h4000_0000 | {a, 2'b00};
    bus_if.dataIn = d;
    @(negedge clk);
    bus_if.ce = 1'b0;
    bus_if.we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus_if.ce   = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = 32'h8000_0000 | {a, 2'b00};
    #1;
    check(name, bus_if.dataOut, exp);
    bus_if.ce = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((m_line.size() != 0 || m_fifo.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < limit), 32'd1);
  endtask

  initial begin
    logic [9:0]  pat;
    logic [29:0] seq;
    int          n;
    rst = 1'b1;
    bus_if.ce = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.dataIn = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and decode.
    check("reset_txd", 32'(txd), 32'd1);
    rd_chk("reset_status", REG_STATUS, 32'h04);
    rd_chk("reset_divisor", REG_DIVISOR, 32'd434);
    rd_chk("reserved_read", REG_RSVD, 32'h0);
    rd_chk("txdata_read", REG_TXDATA, 32'h0);
    bus_if.addr = 32'h4;
    #1 check("ce_low_read", bus_if.dataOut, 32'h0);

    // Single 0x55 frame at divisor 4.
    wr(REG_DIVISOR, 32'd4);
    rd_chk("divisor_4", REG_DIVISOR, 32'd4);
    wr(REG_TXDATA, 32'hFFFF_FF55);
    check("latency_before_pop", 32'(txd), 32'd1);
    pat = 10'b1010101010;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("frame55_bit", 32'(txd), 32'(pat[k/4]));
    end
    @(negedge clk);
    rd_chk("idle_after_40", REG_STATUS, 32'h04);

    // Divisor 0 behaves as 1.
    wr(REG_DIVISOR, 32'd0);
    rd_chk("divisor_0_readback", REG_DIVISOR, 32'd0);
    wr(REG_TXDATA, 32'hA5);
    pat = 10'b1101001010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("frameA5_bit", 32'(txd), 32'(pat[k]));
    end
    @(negedge clk);
    rd_chk("idle_after_10", REG_STATUS, 32'h04);
    rd_chk("reserved_read2", REG_RSVD, 32'h0);

    // Fill: 9 writes fit (one popped), 10th drops, W1C clears.
    wr(REG_DIVISOR, 32'd2);
    for (int i = 0; i < 9; i++) wr(REG_TXDATA, 32'h30 + i);
    rd_chk("nine_queued", REG_STATUS, 32'h83);
    wr(REG_TXDATA, 32'hEE);
    rd_chk("overflow_set", REG_STATUS, 32'h8B);
    wr(REG_STATUS, 32'h08);
    rd_chk("overflow_w1c", REG_STATUS, 32'h83);

    // Write to a full FIFO on the edge where the stop bit completes.
    n = 0;
    while (m_line.size() != 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stop_sync_timeout", 32'(n < 100), 32'd1);
    wr(REG_TXDATA, 32'hC3);
    rd_chk("full_write_at_stop", REG_STATUS, 32'h83);
    wait_idle(400);
    rd_chk("drained", REG_STATUS, 32'h04);

    // Three queued frames at divisor 3 run back to back.
    wr(REG_DIVISOR, 32'd3);
    seq = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 8'h01, 1'b0};
    wr(REG_TXDATA, 32'h01);
    wr(REG_TXDATA, 32'h80);
    check("b2b_bit", 32'(txd), 32'(seq[0]));
    wr(REG_TXDATA, 32'hFF);
    check("b2b_bit", 32'(txd), 32'(seq[0]));
    for (int k = 2; k < 90; k++) begin
      @(negedge clk);
      check("b2b_bit", 32'(txd), 32'(seq[k/3]));
    end
    @(negedge clk);
    rd_chk("idle_after_90", REG_STATUS, 32'h04);

    // Reset during data bit 3; the write in the reset cycle is ignored.
    wr(REG_DIVISOR, 32'd4);
    wr(REG_TXDATA, 32'h00);
    repeat (18) @(negedge clk);
    check("data_bit3_low", 32'(txd), 32'd0);
    rst = 1'b1;
    bus_if.ce = 1'b1; bus_if.we = 1'b1;
    bus_if.addr = 32'h0; bus_if.dataIn = 32'h5A;
    @(negedge clk);
    rst = 1'b0;
    bus_if.ce = 1'b0; bus_if.we = 1'b0;
    check("abort_txd_high", 32'(txd), 32'd1);
    rd_chk("abort_status", REG_STATUS, 32'h04);
    rd_chk("abort_divisor", REG_DIVISOR, 32'd434);

    wr(REG_DIVISOR, 32'd1);
    wr(REG_TXDATA, 32'h3C);
    wait_idle(100);
    rd_chk("final_status", REG_STATUS, 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
